tty_writer: RTL and testbench
=============================

# tty_writer

Text-mode console writer: accepts ASCII bytes over a valid/ready stream and writes character/attribute pairs into the 80x25 text video RAM that the display controller scans. Interprets CR, LF, BS and FF, scrolls the screen up when output passes the last row, and drives the cursor index consumed by the display side. Sits between the CPU/BIOS character-output path and the shared text video RAM write port.

## Interface
- COLS, 80, characters per row
- ROWS, 25, rows per screen (CELLS = COLS*ROWS = 2000, VRAM bytes = 4000)
- BLANK, 8'h20, character used for cleared cells
- clock_25  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  in_data holds a byte
- in_data  in  8  ASCII byte
- in_ready  out  1  block can accept a byte
- attr  in  8  attribute for written/cleared cells, sampled at byte acceptance
- vram_address  out  12  byte address; even = char, odd = attr
- vram_wdata  out  8  write data
- vram_we  out  1  write strobe, one byte per cycle
- vram_rdata  in  8  read data; valid the cycle after vram_address is presented (synchronous RAM)
- cursor  out  11  cursor cell index, 0..CELLS-1

## Operation
- Byte accepted on the cycle with in_valid && in_ready; in_ready = (state == IDLE). in_data and attr latched then.
- Internal col (0..79) and row (0..24) counters; cursor = row*COLS + col, registered, no division.
- 0x0D CR: col = 0. 0x0A LF: row+1; at row 24 -> scroll, row stays 24; col unchanged. 0x08 BS: col>0 -> col-1; col==0 && row>0 -> col=79, row-1; at cell 0 no change; nothing erased. 0x0C FF: clear all 2000 cells to BLANK/attr, cursor 0.
- All other bytes printable: write char to 2*cursor, attr to 2*cursor+1, then col+1; col 80 -> col 0, row+1; row 25 -> scroll, row 24.
- Scroll: for i = 0..3839 copy vram[i+160] -> vram[i] (read cycle then write cycle), then fill bytes 3840..3999 with BLANK (even) / latched attr (odd).
- States: IDLE, WCHAR, WATTR, SCR_RD, SCR_WR, FILL, CLEAR. IDLE -> WCHAR (printable) | CLEAR (FF) | SCR_RD (LF on row 24) | IDLE (CR, BS, LF otherwise). WCHAR -> WATTR -> IDLE or SCR_RD (wrap past cell 1999). SCR_RD <-> SCR_WR until i=3839 written -> FILL -> IDLE after byte 3999. CLEAR -> IDLE after byte 3999.
- vram_we high only in WCHAR, WATTR, SCR_WR, FILL, CLEAR.

## Timing
- Reset values: cursor 0, col/row 0, vram_we 0, vram_address 0, vram_wdata 0, state IDLE (in_ready 1 once reset released).
- Printable accepted at T: T+1 WCHAR write, T+2 WATTR write, cursor updated at T+3, in_ready 1 at T+3 (2-cycle busy).
- CR/BS/LF-without-scroll: cursor updated next cycle, in_ready stays 1 (back-to-back at 1 byte/cycle).
- Scroll: 3840*2 + 160 = 7840 cycles busy; cursor shows final position when in_ready returns.
- Clear: 4000 write cycles; cursor 0 when in_ready returns.
- Reset asserted mid-operation: immediate abort to reset values; VRAM left partially updated, no recovery.
- in_valid held while in_ready low: byte not consumed; in_data may change freely.

## Structure
- Shared package/include tty_pkg: COLS, ROWS, CELLS, VRAM_BYTES, SCROLL_BYTES (3840), BLANK, control codes (CR, LF, BS, FF), state encoding.
- One natural sub-module: tty_cursor (col/row counters, advance/CR/LF/BS/home ops, wrap and needs-scroll flags, cursor product); FSM and VRAM sequencing in tty_writer.

## Test plan
- Reset, send 'A' with attr 0x1F -> writes (0,0x41),(1,0x1F); cursor 1; in_ready low exactly 2 cycles.
- Cursor at col 79 row 3, send 'x' -> writes at bytes 638/639; cursor 320.
- Send CR at cursor 245 -> cursor 240, no writes; BS at cursor 80 -> 79; BS at 0 -> 0.
- Preload VRAM row 1 pattern, cursor 1999, send 'Z' -> 'Z' at byte 3998, scroll: row 0 = old row 1, bytes 3840..3999 = 0x20/attr; cursor 1920; busy 2+7840 cycles.
- Send FF with attr 0x07 -> 2000 cells = 0x20/0x07, cursor 0, 4000 write cycles.
- Assert reset_n low mid-scroll -> vram_we 0 and cursor 0 immediately; next byte accepted normally.

Source files
------------

// File: rtl/tty_pkg.sv
// Shared constants, control codes and encodings for the text-mode console writer.
package tty_pkg;

  localparam int COLS         = 80;
  localparam int ROWS         = 25;
  localparam int CELLS        = COLS * ROWS;
  localparam int VRAM_BYTES   = 2 * CELLS;
  localparam int ROW_BYTES    = 2 * COLS;
  localparam int SCROLL_BYTES = VRAM_BYTES - ROW_BYTES;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    WCHAR,
    WATTR,
    SCR_RD,
    SCR_WR,
    FILL,
    CLEAR
  } state_e;

  typedef enum logic [2:0] {
    CUR_NOP,
    CUR_ADVANCE,
    CUR_CR,
    CUR_LF,
    CUR_BS,
    CUR_HOME
  } cur_op_e;

endpackage

// File: rtl/tty_writer_if.sv
// Byte stream in, text VRAM write/read port and cursor index out.
interface tty_writer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  attr;
  logic [11:0] vram_address;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata;
  logic [10:0] cursor;

  // Writer side.
  modport slave (
    input  in_valid, in_data, attr, vram_rdata,
    output in_ready, vram_address, vram_wdata, vram_we, cursor
  );

  // Host and RAM side.
  modport master (
    output in_valid, in_data, attr, vram_rdata,
    input  in_ready, vram_address, vram_wdata, vram_we, cursor
  );
endinterface

// File: rtl/tty_cursor.sv
// Column/row counters with the cell index kept incrementally alongside them,
// so the cursor never needs a multiply or divide.
module tty_cursor
  import tty_pkg::*;
(
  input  logic        clock_25,
  input  logic        reset_n,
  input  cur_op_e     op,
  output logic [10:0] cursor,
  output logic        last_row,
  output logic        last_cell
);

  logic [6:0] col;
  logic [4:0] row;

  assign last_row  = (row == 5'(ROWS - 1));
  assign last_cell = last_row && (col == 7'(COLS - 1));

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      col    <= '0;
      row    <= '0;
      cursor <= '0;
    end else begin
      case (op)
        CUR_ADVANCE: begin
          if (col == 7'(COLS - 1)) begin
            col <= '0;
            if (last_row) begin
              // Wrapping off the bottom lands at the start of the last row.
              cursor <= 11'(CELLS - COLS);
            end else begin
              row    <= row + 5'd1;
              cursor <= cursor + 11'd1;
            end
          end else begin
            col    <= col + 7'd1;
            cursor <= cursor + 11'd1;
          end
        end
        CUR_CR: begin
          col    <= '0;
          cursor <= cursor - 11'(col);
        end
        CUR_LF: begin
          if (!last_row) begin
            row    <= row + 5'd1;
            cursor <= cursor + 11'(COLS);
          end
        end
        CUR_BS: begin
          if (col != '0) begin
            col    <= col - 7'd1;
            cursor <= cursor - 11'd1;
          end else if (row != '0) begin
            col    <= 7'(COLS - 1);
            row    <= row - 5'd1;
            cursor <= cursor - 11'd1;
          end
        end
        CUR_HOME: begin
          col    <= '0;
          row    <= '0;
          cursor <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tty_writer.sv
// Console writer: accepts ASCII bytes, writes char/attr pairs to text VRAM,
// handles CR/LF/BS/FF and scrolls by copying rows up through the RAM port.
module tty_writer
  import tty_pkg::*;
(
  input  logic         clock_25,
  input  logic         reset_n,
  tty_writer_if.slave  bus
);

  state_e      state;
  logic [11:0] idx;
  logic [11:0] idx_next;
  logic [11:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  attr_q;
  logic        we_q;
  logic        accept;
  logic [10:0] cursor;
  logic        last_row;
  logic        last_cell;
  cur_op_e     cur_op;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign idx_next = idx + 12'd1;

  always_comb begin
    cur_op = CUR_NOP;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.in_data)
            CH_CR:   cur_op = CUR_CR;
            CH_BS:   cur_op = CUR_BS;
            CH_LF:   cur_op = last_row ? CUR_NOP : CUR_LF;
            default: cur_op = CUR_NOP;
          endcase
        end
      end
      WATTR:   cur_op = CUR_ADVANCE;
      CLEAR:   cur_op = (idx == 12'(VRAM_BYTES - 1)) ? CUR_HOME : CUR_NOP;
      default: cur_op = CUR_NOP;
    endcase
  end

  tty_cursor u_cursor (
    .clock_25  (clock_25),
    .reset_n   (reset_n),
    .op        (cur_op),
    .cursor    (cursor),
    .last_row  (last_row),
    .last_cell (last_cell)
  );

  always_ff @(posedge clock_25 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      attr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            attr_q <= bus.attr;
            case (bus.in_data)
              CH_FF: begin
                state   <= CLEAR;
                idx     <= '0;
                addr_q  <= '0;
                wdata_q <= BLANK;
                we_q    <= 1'b1;
              end
              CH_LF: begin
                if (last_row) begin
                  state  <= SCR_RD;
                  idx    <= '0;
                  addr_q <= 12'(ROW_BYTES);
                end
              end
              CH_CR, CH_BS: ;
              default: begin
                state   <= WCHAR;
                addr_q  <= {cursor, 1'b0};
                wdata_q <= bus.in_data;
                we_q    <= 1'b1;
              end
            endcase
          end
        end
        WCHAR: begin
          state   <= WATTR;
          addr_q  <= addr_q + 12'd1;
          wdata_q <= attr_q;
        end
        WATTR: begin
          we_q <= 1'b0;
          if (last_cell) begin
            state  <= SCR_RD;
            idx    <= '0;
            addr_q <= 12'(ROW_BYTES);
          end else begin
            state <= IDLE;
          end
        end
        SCR_RD: begin
          state  <= SCR_WR;
          addr_q <= idx;
          we_q   <= 1'b1;
        end
        SCR_WR: begin
          if (idx == 12'(SCROLL_BYTES - 1)) begin
            state   <= FILL;
            idx     <= 12'(SCROLL_BYTES);
            addr_q  <= 12'(SCROLL_BYTES);
            wdata_q <= BLANK;
          end else begin
            state  <= SCR_RD;
            idx    <= idx_next;
            addr_q <= idx_next + 12'(ROW_BYTES);
            we_q   <= 1'b0;
          end
        end
        FILL, CLEAR: begin
          if (idx == 12'(VRAM_BYTES - 1)) begin
            state <= IDLE;
            we_q  <= 1'b0;
          end else begin
            idx     <= idx_next;
            addr_q  <= idx_next;
            // Even bytes are characters, odd bytes attributes.
            wdata_q <= idx[0] ? BLANK : attr_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: read data arrives one cycle after the read address, i.e. during the
  // write cycle itself, so it is forwarded straight through instead of being
  // registered (registering would cost a third cycle per copied byte).
  assign bus.vram_wdata   = (state == SCR_WR) ? bus.vram_rdata : wdata_q;
  assign bus.vram_address = addr_q;
  assign bus.vram_we      = we_q;
  assign bus.in_ready     = (state == IDLE);
  assign bus.cursor       = cursor;

endmodule

// File: tb/tb_tty_writer.sv
// Scoreboard bench for tty_writer: expected VRAM writes are queued with the
// stimulus and a monitor pops them as the DUT writes; a RAM model sits on the port.
module tb_tty_writer;

  logic clock_25 = 1'b0;
  logic reset_n  = 1'b0;
  always #5 clock_25 = ~clock_25;

  tty_writer_if bus ();

  tty_writer dut (
    .clock_25 (clock_25),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        sb_q[$];
  wr_t        sb_e;
  logic [7:0] mem     [0:3999];
  logic [7:0] exp_mem [0:3999];
  int         checks = 0;
  int         errors = 0;
  bit         sb_on  = 1'b1;
  int         busy;
  int         mm;

  // Synchronous RAM: read data valid the cycle after the address.
  always @(posedge clock_25) begin
    if (int'(bus.vram_address) < 4000) begin
      if (bus.vram_we) mem[bus.vram_address] <= bus.vram_wdata;
      bus.vram_rdata <= mem[bus.vram_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) ^ (i >> 3));
  endfunction

  task automatic push_write(input int a, input logic [7:0] d);
    wr_t w;
    w.a = 12'(a);
    w.d = d;
    sb_q.push_back(w);
    exp_mem[a] = d;
  endtask

  always @(negedge clock_25) begin
    if (reset_n && bus.vram_we && sb_on) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected", bus.vram_address, bus.vram_wdata);
      end else begin
        sb_e = sb_q.pop_front();
        check("wr_addr", 32'(bus.vram_address), 32'(sb_e.a));
        check("wr_data", 32'(bus.vram_wdata), 32'(sb_e.d));
      end
    end
  end

  // Sends one byte; busy returns how many cycles in_ready stayed low afterwards.
  task automatic send(input logic [7:0] d, input logic [7:0] a, output int n);
    int w;
    w = 0;
    @(negedge clock_25);
    while (!bus.in_ready && w < 20000) begin
      @(negedge clock_25);
      w++;
    end
    if (!bus.in_ready) check("send_wait_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.attr     = a;
    @(posedge clock_25);
    #1 bus.in_valid = 1'b0;
    n = 0;
    @(negedge clock_25);
    while (!bus.in_ready && n < 20000) begin
      n++;
      @(negedge clock_25);
    end
    if (!bus.in_ready) check("busy_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic put_char(input logic [7:0] d, input logic [7:0] a, input int cur);
    int n;
    push_write(2 * cur, d);
    push_write(2 * cur + 1, a);
    send(d, a, n);
  endtask

  task automatic send_ctrl(input logic [7:0] d, input int times);
    int n;
    for (int k = 0; k < times; k++) send(d, 8'h00, n);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.attr     = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      mem[i]     <= pat(i);
      exp_mem[i]  = pat(i);
    end
    repeat (3) @(negedge clock_25);
    check("rst_vram_we", 32'(bus.vram_we), 32'd0);
    check("rst_cursor", 32'(bus.cursor), 32'd0);
    reset_n = 1'b1;
    @(negedge clock_25);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_vram_address", 32'(bus.vram_address), 32'd0);
    check("rst_vram_wdata", 32'(bus.vram_wdata), 32'd0);

    // 'A' at home
    push_write(0, 8'h41);
    push_write(1, 8'h1F);
    send(8'h41, 8'h1F, busy);
    check("A_busy", busy, 2);
    check("A_cursor", 32'(bus.cursor), 32'd1);
    check("A_queue_empty", sb_q.size(), 0);

    // CR, LF, BS across row boundary, BS at cell 0
    send(8'h0D, 8'h00, busy);
    check("cr_busy", busy, 0);
    check("cr_cursor_0", 32'(bus.cursor), 32'd0);
    send_ctrl(8'h0A, 1);
    check("lf_cursor_80", 32'(bus.cursor), 32'd80);
    send_ctrl(8'h08, 1);
    check("bs_cursor_79", 32'(bus.cursor), 32'd79);
    send_ctrl(8'h0D, 1);
    send_ctrl(8'h08, 1);
    check("bs_at_0", 32'(bus.cursor), 32'd0);

    // Fill row 3 up to col 79, then 'x' wraps to row 4
    send_ctrl(8'h0A, 3);
    check("lf3_cursor_240", 32'(bus.cursor), 32'd240);
    for (int k = 0; k < 79; k++) put_char(8'h2E, 8'h07, 240 + k);
    check("row3_col79", 32'(bus.cursor), 32'd319);
    put_char(8'h78, 8'h3C, 319);
    check("x_cursor_320", 32'(bus.cursor), 32'd320);
    check("x_queue_empty", sb_q.size(), 0);

    send_ctrl(8'h08, 1);
    check("bs_wrap_319", 32'(bus.cursor), 32'd319);
    send_ctrl(8'h0D, 1);
    for (int k = 0; k < 5; k++) put_char(8'h61 + 8'(k), 8'h05, 240 + k);
    check("cursor_245", 32'(bus.cursor), 32'd245);
    send_ctrl(8'h0D, 1);
    check("cr_245_to_240", 32'(bus.cursor), 32'd240);

    // Three LFs back to back with in_valid held
    @(negedge clock_25);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0A;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock_25);
      check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      check("b2b_cursor", 32'(bus.cursor), 32'(240 + 80 * k));
    end
    bus.in_valid = 1'b0;

    // Wrap past cell 1999 with a preloaded screen -> scroll
    send_ctrl(8'h0A, 18);
    check("cursor_1920", 32'(bus.cursor), 32'd1920);
    for (int k = 0; k < 79; k++) put_char(8'h2D, 8'h02, 1920 + k);
    check("cursor_1999", 32'(bus.cursor), 32'd1999);
    @(negedge clock_25);
    for (int i = 0; i < 4000; i++) begin
      mem[i]     <= pat(i);
      exp_mem[i]  = pat(i);
    end
    @(negedge clock_25);
    push_write(3998, 8'h5A);
    push_write(3999, 8'h4E);
    for (int i = 0; i < 3840; i++) push_write(i, exp_mem[i + 160]);
    for (int i = 3840; i < 4000; i++) push_write(i, (i % 2 == 0) ? 8'h20 : 8'h4E);
    send(8'h5A, 8'h4E, busy);
    check("scroll_busy", busy, 2 + 7840);
    check("scroll_cursor", 32'(bus.cursor), 32'd1920);
    check("scroll_queue_empty", sb_q.size(), 0);
    @(negedge clock_25);
    mm = 0;
    for (int i = 0; i < 160; i++) if (mem[i] !== pat(i + 160)) mm++;
    check("scroll_row0_is_old_row1", mm, 0);
    mm = 0;
    for (int i = 3840; i < 4000; i++) if (mem[i] !== ((i % 2 == 0) ? 8'h20 : 8'h4E)) mm++;
    check("scroll_last_row_blank", mm, 0);

    // Form feed
    for (int i = 0; i < 4000; i++) push_write(i, (i % 2 == 0) ? 8'h20 : 8'h07);
    send(8'h0C, 8'h07, busy);
    check("ff_busy", busy, 4000);
    check("ff_cursor", 32'(bus.cursor), 32'd0);
    check("ff_queue_empty", sb_q.size(), 0);
    @(negedge clock_25);
    mm = 0;
    for (int i = 0; i < 4000; i++) if (mem[i] !== exp_mem[i]) mm++;
    check("ff_ram_image", mm, 0);

    // Reset in the middle of an LF-triggered scroll
    send_ctrl(8'h0A, 24);
    check("pre_abort_cursor", 32'(bus.cursor), 32'd1920);
    sb_on = 1'b0;
    @(negedge clock_25);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0A;
    @(posedge clock_25);
    #1 bus.in_valid = 1'b0;
    repeat (100) @(negedge clock_25);
    check("mid_scroll_busy", 32'(bus.in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_vram_we", 32'(bus.vram_we), 32'd0);
    check("abort_cursor", 32'(bus.cursor), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clock_25);
    reset_n = 1'b1;
    sb_q.delete();
    sb_on = 1'b1;
    push_write(0, 8'h42);
    push_write(1, 8'h12);
    send(8'h42, 8'h12, busy);
    check("post_abort_busy", busy, 2);
    check("post_abort_cursor", 32'(bus.cursor), 32'd1);
    check("post_abort_queue_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
